// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package sub_pkg;

    localparam int SUB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = ai - bi - bin, with borrow out.
module full_subtractor (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = ai ^ bi ^ bin;
    assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor, LSB-first with a registered borrow.
// diff = {borrow_out, (a - b) mod 2^W}, updated once per operation.
module serial_subtractor
    import sub_pkg::*;
#(
    parameter int W = SUB_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W:0]   diff
);

    localparam int CW = $clog2(W + 1);

    state_t        state, nxt;
    logic [W-1:0]  a_sr, b_sr;
    logic [W-2:0]  res;
    logic          br;
    logic [CW-1:0] cnt;
    logic          d, br_n;
    logic [W-1:0]  res_n;
    logic          last;

    full_subtractor u_fs (
        .ai  (a_sr[0]),
        .bi  (b_sr[0]),
        .bin (br),
        .d   (d),
        .bout(br_n)
    );

    // The last difference bit goes straight into diff, so res only holds W-1 bits.
    assign res_n = {d, res};
    assign last  = (cnt == CW'(1));

    always_comb begin
        nxt  = IDLE;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE:    nxt = start ? SHIFT : IDLE;
            SHIFT: begin
                busy = 1'b1;
                nxt  = last ? DONE : SHIFT;
            end
            DONE: begin
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            res   <= '0;
            br    <= 1'b0;
            cnt   <= '0;
            diff  <= '0;
        end else begin
            state <= nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        br   <= 1'b0;
                        cnt  <= CW'(W);
                    end
                end
                SHIFT: begin
                    a_sr <= a_sr >> 1;
                    b_sr <= b_sr >> 1;
                    br   <= br_n;
                    res  <= res_n[W-1:1];
                    cnt  <= cnt - CW'(1);
                    if (last)
                        diff <= {br_n, res_n};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=4): directed table, corner sequences,
// random and exhaustive operand pairs against an arithmetic reference.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done;
    logic [W:0]   diff;

    int n_vec = 0;
    int n_err = 0;

    serial_subtractor #(.W(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .diff (diff)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W:0]   exp;
    } vec_t;

    vec_t tbl [6];

    function automatic logic [W:0] ref_sub(input int x, input int y);
        int dd;
        dd = (x - y) & ((1 << W) - 1);
        return {(x < y) ? 1'b1 : 1'b0, W'(dd)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Full operation with cycle-exact timing checks; inputs are scrambled after acceptance.
    task automatic do_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic [W:0] exp, input string nm);
        @(negedge clk);
        a = xa; b = xb; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        for (int k = 0; k < W; k++) begin
            chk({nm, " busy"}, 32'(busy), 32'd1);
            chk({nm, " early done"}, 32'(done), 32'd0);
            @(negedge clk);
        end
        chk({nm, " done"}, 32'(done), 32'd1);
        chk({nm, " busy at done"}, 32'(busy), 32'd0);
        chk({nm, " diff"}, 32'(diff), 32'(exp));
        @(negedge clk);
        chk({nm, " done width"}, 32'(done), 32'd0);
        chk({nm, " diff hold"}, 32'(diff), 32'(exp));
    endtask

    initial begin
        int ndone;
        tbl[0] = '{4'b0101, 4'b0011, 5'b00010};
        tbl[1] = '{4'b0011, 4'b0101, 5'b11110};
        tbl[2] = '{4'b0000, 4'b0001, 5'b11111};
        tbl[3] = '{4'b1111, 4'b1111, 5'b00000};
        tbl[4] = '{4'b1000, 4'b0111, 5'b00001};
        tbl[5] = '{4'b1001, 4'b0100, 5'b00101};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst busy", 32'(busy), 32'd0);
            chk("rst done", 32'(done), 32'd0);
            chk("rst diff", 32'(diff), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle busy", 32'(busy), 32'd0);
            chk("idle done", 32'(done), 32'd0);
            chk("idle diff", 32'(diff), 32'd0);
        end

        for (int i = 0; i < 6; i++)
            do_op(tbl[i].a, tbl[i].b, tbl[i].exp, $sformatf("tbl%0d", i));

        // start re-asserted with different operands while shifting must be ignored
        @(negedge clk);
        a = 4'b0101; b = 4'b0011; start = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 4'b1111; b = 4'b0000; start = 1'b1;
            chk("midstart busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 4; i < 16; i++) begin
            @(negedge clk);
            if (done) ndone++;
            chk("midstart done", 32'(done), (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) chk("midstart diff", 32'(diff), 32'b00010);
        end
        chk("midstart pulses", 32'(ndone), 32'd1);
        chk("midstart diff hold", 32'(diff), 32'b00010);

        // reset on the second SHIFT edge aborts the operation
        @(negedge clk);
        a = 4'b0000; b = 4'b0001; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort diff", 32'(diff), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort no done", 32'(done), 32'd0);
            chk("abort idle", 32'(busy), 32'd0);
        end
        do_op(4'b0000, 4'b0001, 5'b11111, "after abort");

        // start held high: one result every W+2 cycles
        @(negedge clk);
        a = 4'b1001; b = 4'b0100; start = 1'b1;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            chk("b2b done", 32'(done), (i >= W && (i - W) % (W + 2) == 0) ? 32'd1 : 32'd0);
            if (done) chk("b2b diff", 32'(diff), 32'b00101);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            do_op(ra, rb, ref_sub(int'(ra), int'(rb)), "rand");
        end

        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                do_op(W'(x), W'(y), ref_sub(x, y), $sformatf("all %0d-%0d", x, y));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial W-bit subtractor; the inverse operation of the team's 4-bit adder.
- Computes A − B one bit per clock, LSB-first, using a registered borrow.
- Presents a (W+1)-bit result: borrow flag in the MSB, W-bit difference below it.
- Used where area matters more than latency; also serves as the check path for adder outputs (SUM − B == A).

Parameters:
- W, 4, operand width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  request; sampled only in IDLE.
- a  input  W  minuend; captured on accepting edge.
- b  input  W  subtrahend; captured on accepting edge.
- busy  output  1  high while state == SHIFT.
- done  output  1  one-cycle pulse: diff just updated.
- diff  output  W+1  {borrow_out, (a−b) mod 2^W}; holds until next completion.

Behaviour:
- Reset (rst_n==0 at a rising edge): state=IDLE, busy=0, done=0, diff=0, borrow=0, bit count=0, operand shift registers=0.
- Reset takes priority over every other event, including mid-SHIFT; an aborted operation never raises done, and diff returns to 0.
- States and transitions:
  - IDLE: start=1 → SHIFT. On that edge: a and b are loaded into shift registers, borrow=0, count=W.
  - SHIFT: each edge processes the current LSBs ai, bi with borrow br:
    - di = ai ^ bi ^ br
    - br' = (~ai & bi) | (~(ai ^ bi) & br)
    - di shifts into the result register from the MSB side; operands shift right; count decrements.
    - On the edge where count goes 1→0: state → DONE, and diff <= {br', di, result[W-1:1]}.
  - DONE: done=1 for exactly this one cycle; next edge → IDLE unconditionally.
- Latency: start accepted at edge N → diff valid and done=1 in the cycle after edge N+W. done falls after edge N+W+1. Throughput is one operation per W+2 cycles.
- busy=1 for exactly W cycles: after edge N through edge N+W.
- start while in SHIFT or DONE is ignored. No queuing. a and b may change freely after the accepting edge.
- diff holds its last value through IDLE and through the next SHIFT; it changes only on the completing edge or on reset.
- Width rules:
  - diff[W] = 1 iff a < b (unsigned borrow).
  - diff[W-1:0] is the two's-complement wrap of a−b.
  - There is no overflow beyond the borrow flag.
- start held high continuously: a new operation begins every W+2 cycles. IDLE is visited for one cycle between operations.

Decomposition:
- Shared package/header sub_pkg:
  - State encodings IDLE=2'd0, SHIFT=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE).
  - Default width constant SUB_W=4.
- Natural sub-module: full_subtractor (1-bit, combinational: ai, bi, bin → d, bout), instantiated once in the datapath.
- Top holds the FSM, counter, shift registers and result register.

Test Plan:
- Reset then idle: rst_n low 2 cycles, start=0 → busy=0, done=0, diff=5'b00000 throughout.
- a=4'b0101, b=4'b0011, start pulse at edge N → busy high edges N..N+4, done=1 in cycle after edge N+4, diff=5'b00010.
- Borrow cases, each checked at done:
  - a=0011, b=0101 → diff=5'b11110.
  - a=0000, b=0001 → 5'b11111.
  - a=1111, b=1111 → 5'b00000.
  - a=1000, b=0111 → 5'b00001.
- start asserted again mid-SHIFT with a=1111, b=0000 → ignored; the original result completes, and exactly one done pulse occurs per accepted start.
- Reset mid-op: rst_n=0 at the second SHIFT edge → next cycle state=IDLE, busy=0, diff=0, no done pulse. A fresh start then completes normally.
- Back-to-back: start held high with a=1001, b=0100 → done pulses every 6 cycles, diff=5'b00101 each time.
- Cross-check: for all 256 (a,b) pairs, diff equals {a<b, (a−b)&4'hF}.
